// File: rtl/rr3_mux_arbiter_pkg.sv
// Shared types and helpers for the 3-way round-robin mux arbiter.
// Holds the state encoding, the "no owner" address and the rotation pick.
package rr3_mux_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GRANT   = 2'b01,
        ST_RELEASE = 2'b10
    } state_t;

    localparam logic [1:0] ADR_NONE = 2'b11;

    // First set request searching from last+1 modulo 3; ADR_NONE if nobody asks.
    function automatic logic [1:0] rr_next(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] pick;
        int         idx;
        pick = ADR_NONE;
        for (int k = 2; k >= 0; k--) begin
            idx = (int'(last) + 1 + k) % 3;
            if (req[idx]) begin
                pick = 2'(idx);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr3_mux_arbiter_if.sv
// Bus bundle between three producers, the arbiter and one consumer.
// The arbiter takes the slave view; the producer/consumer side takes the master view.
interface rr3_mux_arbiter_if #(
    parameter int W = 4
);
    logic [2:0]   req;
    logic [W-1:0] x0;
    logic [W-1:0] x1;
    logic [W-1:0] x2;
    logic         ready;
    logic [2:0]   gnt;
    logic [1:0]   adr;
    logic [W-1:0] y;
    logic         y_valid;
    logic [2:0]   beat_ack;

    modport slave (
        input  req, x0, x1, x2, ready,
        output gnt, adr, y, y_valid, beat_ack
    );

    modport master (
        output req, x0, x1, x2, ready,
        input  gnt, adr, y, y_valid, beat_ack
    );
endinterface

// File: rtl/rr3_mux_arbiter_mux3_sel.sv
// W-bit 3-input AND-OR mux addressed by a 2-bit select.
// Address 11 selects nothing, so the output is all zeros.
module mux3_sel #(
    parameter int W = 4
) (
    input  logic [1:0]   adr_i,
    input  logic [W-1:0] d0_i,
    input  logic [W-1:0] d1_i,
    input  logic [W-1:0] d2_i,
    output logic [W-1:0] y_o
);

    assign y_o = ({W{adr_i == 2'b00}} & d0_i)
               | ({W{adr_i == 2'b01}} & d1_i)
               | ({W{adr_i == 2'b10}} & d2_i);

endmodule

// File: rtl/rr3_mux_arbiter.sv
// Round-robin owner sequencer for one shared 3-input mux path, with bursts of
// up to BURST accepted beats and one dead cycle between owners.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | no owner, adr=11, waiting for any request
//   ST_GRANT   | owner drives y, y_valid=1, counting accepted beats
//   ST_RELEASE | single dead cycle, adr=11, then re-pick or go idle
module rr3_mux_arbiter
    import rr3_mux_arbiter_pkg::*;
#(
    parameter int W     = 4,
    parameter int BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    rr3_mux_arbiter_if.slave  bus
);

    state_t     state_q, state_d;
    logic [1:0] adr_q, adr_d;
    logic [2:0] gnt_q, gnt_d;
    logic       vld_q, vld_d;
    logic [1:0] last_q, last_d;
    logic [3:0] cnt_q, cnt_d;

    logic       owner_req;
    logic       accept;
    logic [1:0] pick;

    // gnt_q is one-hot on the owner, so this isolates the owner's request.
    assign owner_req = |(bus.req & gnt_q);
    assign accept    = vld_q & bus.ready & owner_req;
    assign pick      = rr_next(bus.req, last_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            adr_q   <= ADR_NONE;
            gnt_q   <= 3'b000;
            vld_q   <= 1'b0;
            last_q  <= 2'd2;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        gnt_d   = gnt_q;
        vld_d   = vld_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE, ST_RELEASE: begin
                if (bus.req != 3'b000) begin
                    state_d = ST_GRANT;
                    adr_d   = pick;
                    gnt_d   = 3'b001 << pick;
                    vld_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    adr_d   = ADR_NONE;
                    gnt_d   = 3'b000;
                    vld_d   = 1'b0;
                end
                cnt_d = 4'd0;
            end
            ST_GRANT: begin
                if (!owner_req || (accept && cnt_q == 4'(BURST - 1))) begin
                    state_d = ST_RELEASE;
                    adr_d   = ADR_NONE;
                    gnt_d   = 3'b000;
                    vld_d   = 1'b0;
                    last_d  = adr_q;
                    cnt_d   = 4'd0;
                end else if (accept) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                adr_d   = ADR_NONE;
                gnt_d   = 3'b000;
                vld_d   = 1'b0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign bus.gnt      = gnt_q;
    assign bus.adr      = adr_q;
    assign bus.y_valid  = vld_q;
    assign bus.beat_ack = accept ? gnt_q : 3'b000;

    mux3_sel #(.W(W)) u_mux (
        .adr_i (adr_q),
        .d0_i  (bus.x0),
        .d1_i  (bus.x1),
        .d2_i  (bus.x2),
        .y_o   (bus.y)
    );

endmodule

// File: tb/tb_rr3_mux_arbiter.sv
// Self-checking bench for rr3_mux_arbiter: a cycle model pushes expected outputs
// to a scoreboard queue as each stimulus cycle is driven; they are popped and compared.
module tb_rr3_mux_arbiter;

    localparam int W     = 4;
    localparam int BURST = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rr3_mux_arbiter_if #(.W(W)) bus ();

    rr3_mux_arbiter #(.W(W), .BURST(BURST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]   gnt;
        logic [1:0]   adr;
        logic [W-1:0] y;
        logic         vld;
        logic [2:0]   ack;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    // reference model: 0=idle, 1=grant, 2=release
    int m_state = 0;
    int m_own   = 0;
    int m_last  = 2;
    int m_cnt   = 0;

    logic [W-1:0] tx0 = '0, tx1 = '0, tx2 = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model_out(input logic [2:0] req, input logic ready);
        exp_t e;
        e = '0;
        e.adr = 2'b11;
        if (m_state == 1) begin
            e.gnt = 3'(1 << m_own);
            e.adr = 2'(m_own);
            e.vld = 1'b1;
            if (ready && req[m_own]) e.ack = 3'(1 << m_own);
        end
        case (e.adr)
            2'd0:    e.y = tx0;
            2'd1:    e.y = tx1;
            2'd2:    e.y = tx2;
            default: e.y = '0;
        endcase
        return e;
    endfunction

    task automatic model_edge(input logic rst, input logic [2:0] req, input logic ready);
        int c;
        if (!rst) begin
            m_state = 0; m_last = 2; m_cnt = 0;
        end else if (m_state == 1) begin
            if (!req[m_own]) begin
                m_state = 2; m_last = m_own; m_cnt = 0;
            end else if (ready) begin
                m_cnt++;
                if (m_cnt == BURST) begin
                    m_state = 2; m_last = m_own; m_cnt = 0;
                end
            end
        end else begin
            m_state = 0;
            for (int j = 1; j <= 3; j++) begin
                c = (m_last + j) % 3;
                if (m_state == 0 && req[c]) begin
                    m_state = 1; m_own = c; m_cnt = 0;
                end
            end
        end
    endtask

    task automatic step(input logic rst, input logic [2:0] req, input logic ready);
        exp_t e;
        @(negedge clk);
        rst_n     = rst;
        bus.req   = req;
        bus.ready = ready;
        bus.x0    = tx0;
        bus.x1    = tx1;
        bus.x2    = tx2;
        exp_q.push_back(model_out(req, ready));
        #1;
        e = exp_q.pop_front();
        chk("gnt",      32'(bus.gnt),      32'(e.gnt));
        chk("adr",      32'(bus.adr),      32'(e.adr));
        chk("y",        32'(bus.y),        32'(e.y));
        chk("y_valid",  32'(bus.y_valid),  32'(e.vld));
        chk("beat_ack", 32'(bus.beat_ack), 32'(e.ack));
        @(posedge clk);
        model_edge(rst, req, ready);
    endtask

    initial begin
        bus.req   = 3'b000;
        bus.ready = 1'b0;
        bus.x0    = '0;
        bus.x1    = '0;
        bus.x2    = '0;
        rst_n     = 1'b0;
        @(posedge clk);

        // reset held with all requests up
        tx0 = 4'h1; tx1 = 4'h2; tx2 = 4'h3;
        step(1'b0, 3'b111, 1'b1);
        step(1'b0, 3'b111, 1'b1);

        // rotation 0,1,2,0 with full bursts
        for (int i = 0; i < 22; i++) step(1'b1, 3'b111, 1'b1);
        for (int i = 0; i < 3; i++)  step(1'b1, 3'b000, 1'b1);

        // single full burst from requester 0
        tx0 = 4'hA;
        for (int i = 0; i < 5; i++) step(1'b1, 3'b001, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 3'b000, 1'b1);

        // backpressure on owner 1
        step(1'b1, 3'b010, 1'b1);
        step(1'b1, 3'b010, 1'b1);
        step(1'b1, 3'b010, 1'b0);
        step(1'b1, 3'b010, 1'b0);
        step(1'b1, 3'b010, 1'b1);
        step(1'b1, 3'b010, 1'b1);
        step(1'b1, 3'b010, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 3'b000, 1'b1);

        // early release by owner 2 after two beats, then 0 is next
        step(1'b1, 3'b100, 1'b1);
        step(1'b1, 3'b100, 1'b1);
        step(1'b1, 3'b100, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 3'b011, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 3'b000, 1'b1);

        // reset in the middle of owner 0's burst
        step(1'b1, 3'b001, 1'b1);
        step(1'b1, 3'b001, 1'b1);
        step(1'b1, 3'b001, 1'b1);
        step(1'b0, 3'b001, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 3'b111, 1'b1);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            tx0 = 4'($urandom);
            tx1 = 4'($urandom);
            tx2 = 4'($urandom);
            step(($urandom_range(0, 39) != 0), 3'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
